// File: rtl/tx_ts_pkg.sv
// Shared definitions for the multi-channel TX timestamp match/merge path.
// Error bit positions, fingerprint split helpers and response error bundle.
package tx_ts_pkg;

    localparam int DATA_KEEP   = 128;
    localparam int ERR_TIMEOUT = 128;
    localparam int ERR_NOPEND  = 129;

    typedef struct packed {
        logic nopend;
        logic timeout;
    } resp_err_t;

    function automatic logic [31:0] fp_ch(
        input logic [31:0] fp,
        input int          seq_w
    );
        return fp >> seq_w;
    endfunction

    function automatic logic [31:0] fp_seq(
        input logic [31:0] fp,
        input int          seq_w
    );
        return fp & ((32'd1 << seq_w) - 32'd1);
    endfunction

endpackage

// File: rtl/tx_ts_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module tx_ts_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/tx_ts_match_merge.sv
// Per-channel timestamp request tracking, fingerprint matching of returns,
// and zero-latency merge of DMA responses with their timestamps.
module tx_ts_match_merge
    import tx_ts_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int CH_WIDTH       = $clog2(NUM_CH),
    parameter int TS_FP_WIDTH    = 20,
    parameter int DEPTH          = 16,
    parameter int TS_WIDTH       = 96,
    parameter int TS_RESP_WIDTH  = 256,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AGE_WIDTH      = 16
) (
    input  logic                     st_clk,
    input  logic                     st_rst_n,
    input  logic                     sop_valid,
    input  logic [CH_WIDTH-1:0]      sop_ch,
    output logic                     sop_ready,
    output logic                     out_ts_req_valid,
    output logic [TS_FP_WIDTH-1:0]   out_ts_req_fingerprint,
    input  logic                     in_ts_valid,
    input  logic [TS_FP_WIDTH-1:0]   in_ts_fp,
    input  logic [TS_WIDTH-1:0]      in_ts_data,
    input  logic                     in_ts_resp_valid,
    output logic                     in_ts_resp_ready,
    input  logic [CH_WIDTH-1:0]      in_ts_resp_ch,
    input  logic [TS_RESP_WIDTH-1:0] in_ts_resp_data,
    output logic                     out_ts_resp_valid,
    input  logic                     out_ts_resp_ready,
    output logic [TS_RESP_WIDTH-1:0] out_ts_resp_data,
    output logic [15:0]              stale_cnt,
    output logic [15:0]              timeout_cnt
);

    localparam int SEQ  = TS_FP_WIDTH - CH_WIDTH;
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [SEQ-1:0]       tag;
        logic                 done;
        logic [AGE_WIDTH-1:0] issue_time;
        logic [TS_WIDTH-1:0]  ts;
    } entry_t;

    entry_t               pend   [NUM_CH][DEPTH];
    logic [SEQ-1:0]       wr_seq [NUM_CH];
    logic [SEQ-1:0]       rd_seq [NUM_CH];
    logic [CNTW-1:0]      count  [NUM_CH];
    logic [AGE_WIDTH-1:0] now;

    logic            sop_acc;
    logic [IDXW-1:0] wr_idx;

    assign sop_ready = (count[sop_ch] != CNTW'(DEPTH));
    assign sop_acc   = sop_valid & sop_ready;
    assign wr_idx    = wr_seq[sop_ch][IDXW-1:0];

    logic [CH_WIDTH-1:0] ret_ch;
    logic [SEQ-1:0]      ret_seq;
    logic [SEQ-1:0]      ret_off;
    logic [IDXW-1:0]     ret_idx;
    entry_t              ret_e;
    logic                ret_hit;
    logic                ret_ok;

    assign ret_ch  = CH_WIDTH'(fp_ch(32'(in_ts_fp), SEQ));
    assign ret_seq = SEQ'(fp_seq(32'(in_ts_fp), SEQ));
    assign ret_idx = ret_seq[IDXW-1:0];
    assign ret_off = ret_seq - rd_seq[ret_ch];
    assign ret_e   = pend[ret_ch][ret_idx];
    assign ret_hit = in_ts_valid
                   && (ret_off < SEQ'(count[ret_ch]))
                   && (ret_e.tag == ret_seq)
                   && !ret_e.done;

    logic [CH_WIDTH-1:0]  head_ch;
    logic [IDXW-1:0]      head_idx;
    entry_t               head;
    logic                 empty;
    logic [AGE_WIDTH-1:0] age;
    logic                 aged;
    logic                 resolvable;
    logic                 pop;
    resp_err_t            err;

    assign head_ch  = in_ts_resp_ch;
    assign head_idx = rd_seq[head_ch][IDXW-1:0];
    assign head     = pend[head_ch][head_idx];
    assign empty    = (count[head_ch] == '0);
    assign age      = now - head.issue_time;
    assign aged     = (TIMEOUT_CYCLES != 0)
                   && (age >= AGE_WIDTH'(TIMEOUT_CYCLES));

    assign err.nopend  = empty;
    assign err.timeout = !empty && !head.done && aged;
    assign resolvable  = empty || head.done || aged;

    assign out_ts_resp_valid = in_ts_resp_valid & resolvable;
    assign in_ts_resp_ready  = out_ts_resp_ready & resolvable;
    assign pop = in_ts_resp_valid && out_ts_resp_ready
              && resolvable && !empty;

    // A return racing the timeout pop of its own entry loses.
    assign ret_ok = ret_hit
                 && !(pop && head_ch == ret_ch
                      && rd_seq[head_ch] == ret_seq);

    always_comb begin
        out_ts_resp_data = '0;
        out_ts_resp_data[DATA_KEEP-1:0] =
            in_ts_resp_data[DATA_KEEP-1:0];
        out_ts_resp_data[ERR_TIMEOUT] = err.timeout;
        out_ts_resp_data[ERR_NOPEND]  = err.nopend;
        if (!(err.timeout || err.nopend)) begin
            out_ts_resp_data[TS_RESP_WIDTH-1 -: TS_WIDTH] = head.ts;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{in_ts_resp_data[TS_RESP_WIDTH-1:DATA_KEEP],
                           head.tag, ret_e.issue_time, ret_e.ts};

    always_ff @(posedge st_clk or negedge st_rst_n) begin
        if (!st_rst_n) begin
            now                    <= '0;
            out_ts_req_valid       <= 1'b0;
            out_ts_req_fingerprint <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_seq[c] <= '0;
                rd_seq[c] <= '0;
                count[c]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    pend[c][i] <= '0;
                end
            end
        end else begin
            now              <= now + 1'b1;
            out_ts_req_valid <= sop_acc;
            if (sop_acc) begin
                out_ts_req_fingerprint <= {sop_ch, wr_seq[sop_ch]};
                pend[sop_ch][wr_idx]   <= '{tag:        wr_seq[sop_ch],
                                            done:       1'b0,
                                            issue_time: now,
                                            ts:         '0};
                wr_seq[sop_ch] <= wr_seq[sop_ch] + 1'b1;
            end
            if (ret_ok) begin
                pend[ret_ch][ret_idx].done <= 1'b1;
                pend[ret_ch][ret_idx].ts   <= in_ts_data;
            end
            if (pop) begin
                pend[head_ch][head_idx].done <= 1'b0;
                rd_seq[head_ch] <= rd_seq[head_ch] + 1'b1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                count[c] <= count[c]
                          + CNTW'(sop_acc && sop_ch == CH_WIDTH'(c))
                          - CNTW'(pop && head_ch == CH_WIDTH'(c));
            end
        end
    end

    tx_ts_sat_cnt u_stale_cnt (
        .clk   (st_clk),
        .rst_n (st_rst_n),
        .inc   (in_ts_valid & ~ret_ok),
        .cnt   (stale_cnt)
    );

    tx_ts_sat_cnt u_timeout_cnt (
        .clk   (st_clk),
        .rst_n (st_rst_n),
        .inc   (pop & err.timeout),
        .cnt   (timeout_cnt)
    );

endmodule

// File: tb/tb_tx_ts_match_merge.sv
// Directed bench: expected merged responses queued at stimulus time,
// compared when the DUT presents each response.
module tb_tx_ts_match_merge;

    localparam int TSW = 96;
    localparam int RW  = 256;

    logic            st_clk = 1'b0;
    logic            st_rst_n = 1'b0;
    logic            sop_valid = 1'b0;
    logic [2:0]      sop_ch = '0;
    logic            sop_ready;
    logic            out_ts_req_valid;
    logic [19:0]     out_ts_req_fingerprint;
    logic            in_ts_valid = 1'b0;
    logic [19:0]     in_ts_fp = '0;
    logic [TSW-1:0]  in_ts_data = '0;
    logic            in_ts_resp_valid = 1'b0;
    logic            in_ts_resp_ready;
    logic [2:0]      in_ts_resp_ch = '0;
    logic [RW-1:0]   in_ts_resp_data = '0;
    logic            out_ts_resp_valid;
    logic            out_ts_resp_ready = 1'b1;
    logic [RW-1:0]   out_ts_resp_data;
    logic [15:0]     stale_cnt;
    logic [15:0]     timeout_cnt;

    always #5 st_clk = ~st_clk;

    tx_ts_match_merge #(
        .NUM_CH         (8),
        .TS_FP_WIDTH    (20),
        .DEPTH          (16),
        .TS_WIDTH       (TSW),
        .TS_RESP_WIDTH  (RW),
        .TIMEOUT_CYCLES (64),
        .AGE_WIDTH      (16)
    ) dut (
        .st_clk                 (st_clk),
        .st_rst_n               (st_rst_n),
        .sop_valid              (sop_valid),
        .sop_ch                 (sop_ch),
        .sop_ready              (sop_ready),
        .out_ts_req_valid       (out_ts_req_valid),
        .out_ts_req_fingerprint (out_ts_req_fingerprint),
        .in_ts_valid            (in_ts_valid),
        .in_ts_fp               (in_ts_fp),
        .in_ts_data             (in_ts_data),
        .in_ts_resp_valid       (in_ts_resp_valid),
        .in_ts_resp_ready       (in_ts_resp_ready),
        .in_ts_resp_ch          (in_ts_resp_ch),
        .in_ts_resp_data        (in_ts_resp_data),
        .out_ts_resp_valid      (out_ts_resp_valid),
        .out_ts_resp_ready      (out_ts_resp_ready),
        .out_ts_resp_data       (out_ts_resp_data),
        .stale_cnt              (stale_cnt),
        .timeout_cnt            (timeout_cnt)
    );

    int            checks = 0;
    int            failures = 0;
    logic [RW-1:0] sb [$];
    int            seq_m [8];

    task automatic check(input string tag,
                         input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge st_clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mk(input logic [127:0] d,
                                         input logic [TSW-1:0] ts,
                                         input logic to,
                                         input logic np);
        logic [RW-1:0] r;
        r = '0;
        r[127:0] = d;
        r[128] = to;
        r[129] = np;
        r[RW-1 -: TSW] = ts;
        return r;
    endfunction

    function automatic logic [19:0] fp_of(input int ch, input int seq);
        return {3'(ch), 17'(seq)};
    endfunction

    task automatic sop(input int ch);
        logic [19:0] fp;
        fp = fp_of(ch, seq_m[ch]);
        sop_valid = 1'b1;
        sop_ch = 3'(ch);
        #1;
        check("sop_ready", RW'(sop_ready), RW'(1));
        tick;
        sop_valid = 1'b0;
        check("req_valid", RW'(out_ts_req_valid), RW'(1));
        check("req_fp", RW'(out_ts_req_fingerprint), RW'(fp));
        seq_m[ch]++;
    endtask

    task automatic ret(input logic [19:0] fp, input logic [TSW-1:0] ts);
        in_ts_valid = 1'b1;
        in_ts_fp = fp;
        in_ts_data = ts;
        tick;
        in_ts_valid = 1'b0;
    endtask

    task automatic resp(input int ch, input logic [127:0] d,
                        output int waited);
        logic [RW-1:0] exp;
        in_ts_resp_valid = 1'b1;
        in_ts_resp_ch = 3'(ch);
        in_ts_resp_data = {128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, d};
        #1;
        waited = 0;
        while (!out_ts_resp_valid && waited < 300) begin
            tick;
            waited++;
        end
        check("resp_valid", RW'(out_ts_resp_valid), RW'(1));
        check("resp_ready", RW'(in_ts_resp_ready), RW'(1));
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        check("resp_data", out_ts_resp_data, exp);
        tick;
        in_ts_resp_valid = 1'b0;
    endtask

    initial begin
        int w;
        logic [TSW-1:0] ts;
        logic [127:0] d;
        for (int i = 0; i < 8; i++) seq_m[i] = 0;

        #12;
        check("rst_req_valid", RW'(out_ts_req_valid), RW'(0));
        check("rst_req_fp", RW'(out_ts_req_fingerprint), RW'(0));
        check("rst_stale", RW'(stale_cnt), RW'(0));
        check("rst_timeout", RW'(timeout_cnt), RW'(0));
        check("rst_sop_ready", RW'(sop_ready), RW'(1));
        check("rst_resp_valid", RW'(out_ts_resp_valid), RW'(0));
        @(negedge st_clk);
        st_rst_n = 1'b1;
        tick;

        // in-order returns on ch3
        for (int i = 0; i < 3; i++) sop(3);
        for (int i = 0; i < 3; i++) begin
            ts = 96'h1111_2222_3333_4444_5555_0000 + TSW'(i);
            ret(fp_of(3, i), ts);
        end
        for (int i = 0; i < 3; i++) begin
            ts = 96'h1111_2222_3333_4444_5555_0000 + TSW'(i);
            d = 128'hC3C3_0000 + 128'(i);
            sb.push_back(mk(d, ts, 1'b0, 1'b0));
            resp(3, d, w);
        end
        check("stale_after_ch3", RW'(stale_cnt), RW'(0));

        // out-of-order returns on ch5
        sop(5);
        sop(5);
        ret(fp_of(5, 1), 96'hBBBB_0001);
        ret(fp_of(5, 0), 96'hBBBB_0000);
        sb.push_back(mk(128'hD0, 96'hBBBB_0000, 1'b0, 1'b0));
        resp(5, 128'hD0, w);
        sb.push_back(mk(128'hD1, 96'hBBBB_0001, 1'b0, 1'b0));
        resp(5, 128'hD1, w);

        // response with nothing pending
        sb.push_back(mk(128'hE7, '0, 1'b0, 1'b1));
        resp(7, 128'hE7, w);
        check("nopend_wait", RW'(w), RW'(0));

        // fill ch0, then pop while a SOP is presented
        for (int i = 0; i < 16; i++) sop(0);
        ret(fp_of(0, 0), 96'hCCCC_0000);
        sop_valid = 1'b1;
        sop_ch = 3'd0;
        #1;
        check("full_sop_ready", RW'(sop_ready), RW'(0));
        sb.push_back(mk(128'hF0, 96'hCCCC_0000, 1'b0, 1'b0));
        resp(0, 128'hF0, w);
        sop_valid = 1'b0;
        check("full_sop_blocked", RW'(out_ts_req_valid), RW'(0));
        sop(0);
        check("refull_sop_ready", RW'(sop_ready), RW'(0));

        // timeout on ch1, then a late return is stale
        sop(1);
        sb.push_back(mk(128'h71, '0, 1'b1, 1'b0));
        resp(1, 128'h71, w);
        check("timeout_wait", RW'(w), RW'(63));
        check("timeout_cnt", RW'(timeout_cnt), RW'(1));
        ret(20'h20000, 96'hDEAD);
        check("stale_cnt", RW'(stale_cnt), RW'(1));

        // asynchronous reset with entries pending
        sop(4);
        sop_ch = 3'd0;
        #1;
        check("pre_rst_ready", RW'(sop_ready), RW'(0));
        st_rst_n = 1'b0;
        #1;
        check("arst_req_valid", RW'(out_ts_req_valid), RW'(0));
        check("arst_req_fp", RW'(out_ts_req_fingerprint), RW'(0));
        check("arst_stale", RW'(stale_cnt), RW'(0));
        check("arst_timeout", RW'(timeout_cnt), RW'(0));
        check("arst_sop_ready", RW'(sop_ready), RW'(1));
        repeat (2) @(posedge st_clk);
        @(negedge st_clk);
        st_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) seq_m[i] = 0;
        tick;
        sop(2);
        check("post_rst_fp", RW'(out_ts_req_fingerprint), RW'(20'h40000));
        sb.push_back(mk(128'h99, '0, 1'b0, 1'b1));
        resp(0, 128'h99, w);
        check("post_rst_nopend_wait", RW'(w), RW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
